// File: rtl/mac_rr_sched.sv
// Round-robin scheduler sharing one integer MAC between two dot-product requesters.
// Clears the MAC, feeds one operand pair at a time and returns the MAC result per job.
module mac_rr_sched #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned TMO   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_start,
  input  logic [2*LEN_W-1:0] req_len,
  input  logic [1:0]         op_vld,
  input  logic [15:0]        op_a,
  input  logic [15:0]        op_b,
  output logic [1:0]         op_rdy,
  output logic [1:0]         gnt,
  output logic [1:0]         res_vld,
  output logic [15:0]        res_y,
  output logic               res_ovf,
  output logic               res_err,
  output logic               mac_clr,
  output logic               mac_valid,
  output logic [7:0]         mac_a,
  output logic [7:0]         mac_b,
  input  logic [15:0]        mac_y,
  input  logic               mac_overflow,
  input  logic               mac_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd1;
  localparam logic [2:0] FEED   = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] RESULT = 3'd4;

  localparam int unsigned TMO_W = $clog2(TMO + 1);

  logic [2:0]       state_q, state_d;
  logic             id_q, id_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             ovf_q, ovf_d;
  logic             rr_last_q, rr_last_d;
  logic [15:0]      res_y_q, res_y_d;
  logic             res_ovf_q, res_ovf_d;
  logic             res_err_q, res_err_d;
  logic             mac_valid_q, mac_valid_d;
  logic [7:0]       mac_a_q, mac_a_d;
  logic [7:0]       mac_b_q, mac_b_d;

  logic             pick_id;
  logic [LEN_W-1:0] pick_len;
  logic [1:0]       id_onehot;

  // On a tie the requester that was not served last wins.
  assign pick_id   = (req_start == 2'b11) ? ~rr_last_q : req_start[1];
  assign pick_len  = pick_id ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
  assign id_onehot = {id_q, ~id_q};

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    ovf_d       = ovf_q;
    rr_last_d   = rr_last_q;
    res_y_d     = res_y_q;
    res_ovf_d   = res_ovf_q;
    res_err_d   = res_err_q;
    mac_valid_d = 1'b0;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;

    case (state_q)
      IDLE: begin
        if (|req_start) begin
          id_d  = pick_id;
          len_d = pick_len;
          ovf_d = 1'b0;
          if (pick_len == '0) begin
            res_y_d   = 16'd0;
            res_ovf_d = 1'b0;
            res_err_d = 1'b0;
            state_d   = RESULT;
          end else begin
            state_d = CLEAR;
          end
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = FEED;
      end
      FEED: begin
        if (op_vld[id_q]) begin
          mac_a_d     = id_q ? op_a[15:8] : op_a[7:0];
          mac_b_d     = id_q ? op_b[15:8] : op_b[7:0];
          mac_valid_d = 1'b1;
          cnt_d       = cnt_q + LEN_W'(1);
          tmo_d       = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        // A done arriving on the timeout cycle still counts as success.
        if (mac_done) begin
          ovf_d = ovf_q | mac_overflow;
          if (cnt_q == len_q) begin
            res_y_d   = mac_y;
            res_ovf_d = ovf_q | mac_overflow;
            res_err_d = 1'b0;
            state_d   = RESULT;
          end else begin
            state_d = FEED;
          end
        end else if (tmo_q == TMO_W'(TMO - 1)) begin
          res_y_d   = mac_y;
          res_ovf_d = ovf_q;
          res_err_d = 1'b1;
          state_d   = RESULT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RESULT: begin
        rr_last_d = id_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      id_q        <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      ovf_q       <= 1'b0;
      rr_last_q   <= 1'b1;
      res_y_q     <= 16'd0;
      res_ovf_q   <= 1'b0;
      res_err_q   <= 1'b0;
      mac_valid_q <= 1'b0;
      mac_a_q     <= 8'd0;
      mac_b_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      ovf_q       <= ovf_d;
      rr_last_q   <= rr_last_d;
      res_y_q     <= res_y_d;
      res_ovf_q   <= res_ovf_d;
      res_err_q   <= res_err_d;
      mac_valid_q <= mac_valid_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
    end
  end

  assign op_rdy    = (state_q == FEED) ? id_onehot : 2'b00;
  assign gnt       = (state_q != IDLE) ? id_onehot : 2'b00;
  assign res_vld   = (state_q == RESULT) ? id_onehot : 2'b00;
  assign mac_clr   = (state_q == CLEAR);
  assign mac_valid = mac_valid_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign res_y     = res_y_q;
  assign res_ovf   = res_ovf_q;
  assign res_err   = res_err_q;

endmodule

// File: doc/mac_rr_sched.md
Name: mac_rr_sched

Overview:
- Round-robin scheduler that shares one integer MAC (mac_int_fsm: valid/A/B in, y/overflow/done out) between two requesters.
- Each requester submits a dot-product job of length LEN and streams signed 8-bit operand pairs through a valid/ready handshake.
- The scheduler clears the MAC, feeds one pair at a time, waits for MAC done, and returns the 16-bit result with sticky overflow.
- Sits between the requesters and the MAC datapath.

Parameters:
- LEN_W, 8, width of job length (max 255 pairs)
- TMO, 16, max cycles to wait for mac_done per pair before aborting the job

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset (asserted at 0)
- req_start  in  2  level job request per requester; held until its gnt bit rises
- req_len  in  2*LEN_W  job length per requester; [LEN_W-1:0] is req0; sampled at grant
- op_vld  in  2  operand pair valid per requester
- op_a  in  16  signed operand A per requester; [7:0] is req0
- op_b  in  16  signed operand B per requester; [7:0] is req0
- op_rdy  out  2  operand ready; only the granted bit is ever 1
- gnt  out  2  one-hot grant, high from grant cycle through RESULT
- res_vld  out  2  one-cycle result strobe to the owning requester
- res_y  out  16  signed accumulated result
- res_ovf  out  1  sticky overflow for the job
- res_err  out  1  job aborted by timeout
- mac_clr  out  1  one-cycle active-high clear to MAC reset input
- mac_valid  out  1  one-cycle operand strobe to MAC
- mac_a  out  8  signed operand to MAC
- mac_b  out  8  signed operand to MAC
- mac_y  in  16  MAC accumulator value
- mac_overflow  in  1  MAC overflow flag
- mac_done  in  1  MAC completion pulse

Behaviour:
- Reset (reset=0 at a clk edge):
  - state IDLE; all outputs 0; counters 0.
  - rr_last=1, so req0 wins the first tie.
  - Reset mid-job abandons the job with no res_vld.
- FSM states: IDLE, CLEAR, FEED, WAIT, RESULT.
- IDLE:
  - If any req_start bit is set, grant one requester. On a tie, grant the requester != rr_last.
  - Latch len and id; set gnt one-hot next cycle; clear ovf_sticky and err.
  - len==0: go to RESULT with res_y=0, res_ovf=0, and no MAC activity.
  - Otherwise go to CLEAR.
- CLEAR: mac_clr=1 for exactly one cycle; cnt=0; go to FEED.
- FEED:
  - op_rdy[id]=1, combinational from state.
  - Handshake when op_vld[id]&&op_rdy[id]: register mac_a/mac_b, mac_valid=1 on the next cycle only, cnt++, tmo_cnt=0, go to WAIT.
  - op_vld of the non-granted requester is ignored.
- WAIT:
  - op_rdy=0; tmo_cnt increments each cycle.
  - On mac_done: ovf_sticky|=mac_overflow. If cnt==len, capture res_y=mac_y and go to RESULT; else go to FEED.
  - If tmo_cnt reaches TMO without mac_done: res_err=1, res_y=mac_y, go to RESULT.
  - mac_done and timeout in the same cycle: mac_done wins.
- RESULT:
  - res_vld[id]=1 for one cycle; res_y, res_ovf and res_err are held stable until the next job's RESULT.
  - rr_last=id; gnt clears; return to IDLE. The next grant is no earlier than the following cycle.
- Timing:
  - mac_valid pulses are never closer than one MAC done apart; at most one pair is in flight.
  - req_start changes outside IDLE are ignored; a dropped request is simply not granted.
- Arithmetic: no accumulation in the scheduler. res_y is the MAC value; overflow is sourced only from mac_overflow and made sticky per job.
- Minimum job latency from grant, with MAC done latency D: 2 + len*(2+D) cycles to res_vld.

Test Plan:
- Single job req0, len=2, pairs (30,40),(10,8) -> one mac_clr, two mac_valid pulses; res_vld[0] with res_y=1280, res_ovf=0, res_err=0.
- req1, len=2, pairs (100,-2),(11,-11) -> res_vld[1], res_y=-321; op_rdy[0] stays 0 throughout.
- Both req_start high at the same cycle after reset -> req0 granted first, then req1. A second simultaneous pair after that -> req0 again (alternation via rr_last).
- req0, len=3, all pairs (127,127) -> res_ovf=1 (48387 exceeds 32767); the next job reports res_ovf=0.
- len=0 request -> res_vld after IDLE→RESULT with res_y=0, and no mac_clr or mac_valid.
- MAC model suppresses mac_done -> res_err=1 after exactly TMO WAIT cycles. Then assert reset=0 mid-FEED of a new job -> all outputs 0, no res_vld, and req0 is granted first after release.
